// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the iterative multiplier: ALU control codes and FSM states.
package alu_mul_seq_pkg;

  // ALU control field: {A_invert, B_invert, operation[1:0]}
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Bus bundle between the multiplier and the CPU side (start/operands/product and
// the borrowed-ALU req/gnt/operand/result path). Port names keep their original
// _i/_o direction suffixes as seen from the multiplier.
interface alu_mul_seq_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [WIDTH-1:0] mcand_i;
  logic [WIDTH-1:0] mplier_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] prod_hi_o;
  logic [WIDTH-1:0] prod_lo_o;
  logic             alu_req_o;
  logic             alu_gnt_i;
  logic [WIDTH-1:0] alu_src1_o;
  logic [WIDTH-1:0] alu_src2_o;
  logic [3:0]       alu_ctrl_o;
  logic [WIDTH-1:0] alu_result_i;
  logic             alu_cout_i;

  // CPU / datapath side
  modport master (
    output start_i, mcand_i, mplier_i, alu_gnt_i, alu_result_i, alu_cout_i,
    input  busy_o, done_o, prod_hi_o, prod_lo_o,
           alu_req_o, alu_src1_o, alu_src2_o, alu_ctrl_o
  );

  // Multiplier side
  modport slave (
    input  start_i, mcand_i, mplier_i, alu_gnt_i, alu_result_i, alu_cout_i,
    output busy_o, done_o, prod_hi_o, prod_lo_o,
           alu_req_o, alu_src1_o, alu_src2_o, alu_ctrl_o
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier. Borrows the shared ALU for WIDTH
// add/shift steps via req/gnt and produces a 2*WIDTH-bit product in {hi, lo}.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  alu_mul_seq_if.slave  bus
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               alu_req;
  logic [WIDTH-1:0]   alu_src1;
  logic [WIDTH-1:0]   alu_src2;
  logic [3:0]         alu_ctrl;

  // State and datapath registers; asynchronous reset clears everything.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, shift-add step and ALU operand drive.
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    alu_req  = 1'b0;
    alu_src1 = '0;
    alu_src2 = '0;
    alu_ctrl = ALU_AND;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start_i) begin
          mcand_d = bus.mcand_i;
          hi_d    = '0;
          lo_d    = bus.mplier_i;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        alu_req  = 1'b1;
        alu_src1 = hi_q;
        alu_src2 = lo_q[0] ? mcand_q : '0;
        alu_ctrl = ALU_ADD;
        // The ALU sum plus carry is WIDTH+1 bits; shifting it right by one
        // spills its LSB into the top of lo while lo shifts out its LSB.
        if (bus.alu_gnt_i) begin
          hi_d  = {bus.alu_cout_i, bus.alu_result_i[WIDTH-1:1]};
          lo_d  = {bus.alu_result_i[0], lo_q[WIDTH-1:1]};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = DONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy_o     = (state_q == RUN);
  assign bus.done_o     = (state_q == DONE);
  assign bus.prod_hi_o  = hi_q;
  assign bus.prod_lo_o  = lo_q;
  assign bus.alu_req_o  = alu_req;
  assign bus.alu_src1_o = alu_src1;
  assign bus.alu_src2_o = alu_src2;
  assign bus.alu_ctrl_o = alu_ctrl;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: WIDTH=32 and WIDTH=4 instances, ALU modelled
// as a combinational adder with carry, products checked against plain multiplication.
module tb_alu_mul_seq;
  import alu_mul_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_mul_seq_if #(.WIDTH(32)) b32 ();
  alu_mul_seq_if #(.WIDTH(4))  b4 ();

  alu_mul_seq #(.WIDTH(32)) dut32 (.clk_i(clk), .rst_i(rst), .bus(b32.slave));
  alu_mul_seq #(.WIDTH(4))  dut4  (.clk_i(clk), .rst_i(rst), .bus(b4.slave));

  // Behavioural ALUs: plain adders with carry out.
  assign {b32.alu_cout_i, b32.alu_result_i} = 33'(b32.alu_src1_o) + 33'(b32.alu_src2_o);
  assign {b4.alu_cout_i,  b4.alu_result_i}  = 5'(b4.alu_src1_o)   + 5'(b4.alu_src2_o);

  // Runs one 32-bit multiply. gnt_pct is grant probability in percent; pulse_at
  // raises start_i with junk operands at that RUN cycle index (-1 = never).
  // Returns at #1 after the edge where done_o is seen (or budget expired).
  task automatic do_mul32(input logic [31:0] a, input logic [31:0] b,
                          input int gnt_pct, input int pulse_at,
                          output logic [31:0] hi, output logic [31:0] lo,
                          output int cycles, output int grants,
                          output int stall_bad, output bit timeout);
    logic        prev_req, prev_gnt;
    logic [31:0] ps1, ps2;
    logic [3:0]  pc;
    grants = 0; stall_bad = 0;
    prev_req = 1'b0; prev_gnt = 1'b1; ps1 = '0; ps2 = '0; pc = '0;
    @(posedge clk); #1;
    b32.start_i  = 1'b1;
    b32.mcand_i  = a;
    b32.mplier_i = b;
    @(posedge clk); #1;
    b32.start_i = 1'b0;
    cycles = 1;
    while (!b32.done_o && cycles < 2000) begin
      if (prev_req && !prev_gnt &&
          (b32.alu_src1_o !== ps1 || b32.alu_src2_o !== ps2 || b32.alu_ctrl_o !== pc))
        stall_bad++;
      if (cycles == pulse_at) begin
        b32.start_i  = 1'b1;
        b32.mcand_i  = $urandom;
        b32.mplier_i = $urandom;
      end else begin
        b32.start_i = 1'b0;
      end
      b32.alu_gnt_i = ($urandom_range(99) < gnt_pct);
      if (b32.alu_req_o && b32.alu_gnt_i) grants++;
      prev_req = b32.alu_req_o; prev_gnt = b32.alu_gnt_i;
      ps1 = b32.alu_src1_o; ps2 = b32.alu_src2_o; pc = b32.alu_ctrl_o;
      @(posedge clk); #1;
      cycles++;
    end
    b32.start_i = 1'b0;
    timeout = !b32.done_o;
    hi = b32.prod_hi_o;
    lo = b32.prod_lo_o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b32.start_i = 1'b0; b32.mcand_i = '0; b32.mplier_i = '0; b32.alu_gnt_i = 1'b1;
    b4.start_i  = 1'b0; b4.mcand_i  = '0; b4.mplier_i  = '0; b4.alu_gnt_i  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (b32.busy_o !== 1'b0 || b32.done_o !== 1'b0) begin bad++;
      $display("FAIL reset_flags: busy=%b done=%b required 0 0", b32.busy_o, b32.done_o); end
    total++; if ({b32.prod_hi_o, b32.prod_lo_o} !== 64'd0) begin bad++;
      $display("FAIL reset_prod: got %h required 0", {b32.prod_hi_o, b32.prod_lo_o}); end
    total++; if (b32.alu_req_o !== 1'b0 || b32.alu_src1_o !== 32'd0 || b32.alu_src2_o !== 32'd0) begin bad++;
      $display("FAIL reset_alu: req=%b src1=%h src2=%h required 0", b32.alu_req_o, b32.alu_src1_o, b32.alu_src2_o); end
    total++; if (b32.alu_ctrl_o !== 4'b0000) begin bad++;
      $display("FAIL reset_ctrl: got %b required 0000", b32.alu_ctrl_o); end
    total++; if ({b4.busy_o, b4.done_o, b4.alu_req_o, b4.prod_hi_o, b4.prod_lo_o} !== 11'd0) begin bad++;
      $display("FAIL reset_w4: outputs not zero"); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (b32.busy_o !== 1'b0 || b32.alu_req_o !== 1'b0) begin bad++;
      $display("FAIL idle_after_reset: busy=%b req=%b required 0 0", b32.busy_o, b32.alu_req_o); end
  endtask

  task automatic test_basic();
    logic [31:0] hi, lo; int cyc, gr, sb; bit to;
    do_mul32(32'd3, 32'd5, 100, -1, hi, lo, cyc, gr, sb, to);
    total++; if (to || cyc != 33) begin bad++;
      $display("FAIL basic_latency: cycles=%0d timeout=%0d required 33", cyc, to); end
    total++; if (hi !== 32'd0 || lo !== 32'd15) begin bad++;
      $display("FAIL basic_prod: got %h_%h required 0_f", hi, lo); end
    total++; if (b32.busy_o !== 1'b0 || b32.alu_req_o !== 1'b0 || b32.alu_ctrl_o !== 4'b0000) begin bad++;
      $display("FAIL basic_done_cycle: busy=%b req=%b ctrl=%b required 0 0 0000", b32.busy_o, b32.alu_req_o, b32.alu_ctrl_o); end
    @(posedge clk); #1;
    total++; if (b32.done_o !== 1'b0 || b32.prod_lo_o !== 32'd15) begin bad++;
      $display("FAIL basic_pulse_hold: done=%b lo=%h required 0 f", b32.done_o, b32.prod_lo_o); end
  endtask

  task automatic test_carry();
    logic [31:0] hi, lo; int cyc, gr, sb; bit to;
    do_mul32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 100, -1, hi, lo, cyc, gr, sb, to);
    total++; if (to || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin bad++;
      $display("FAIL carry_prod: got %h_%h required fffffffe_00000001", hi, lo); end
  endtask

  task automatic test_stall();
    logic [31:0] hi, lo; int cyc, gr, sb; bit to;
    logic [63:0] expv;
    expv = 64'h1234_5678 * 64'h9ABC_DEF0;
    do_mul32(32'h1234_5678, 32'h9ABC_DEF0, 50, -1, hi, lo, cyc, gr, sb, to);
    total++; if (to || {hi, lo} !== expv) begin bad++;
      $display("FAIL stall_prod: got %h required %h", {hi, lo}, expv); end
    total++; if (gr != 32) begin bad++;
      $display("FAIL stall_grants: got %0d required 32", gr); end
    total++; if (sb != 0) begin bad++;
      $display("FAIL stall_stable: %0d unstable stall cycles required 0", sb); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, hi, lo; int cyc, gr, sb; bit to;
    logic [63:0] expv;
    for (int unsigned i = 0; i < 6; i++) begin
      a = $urandom; b = $urandom;
      if (i == 0) a = 32'd0;
      expv = 64'(a) * 64'(b);
      do_mul32(a, b, 60, -1, hi, lo, cyc, gr, sb, to);
      total++; if (to || {hi, lo} !== expv || gr != 32 || sb != 0) begin bad++;
        $display("FAIL random_%0d: %h x %h got %h required %h grants=%0d stall_bad=%0d",
                 i, a, b, {hi, lo}, expv, gr, sb); end
    end
  endtask

  task automatic test_start_in_run();
    logic [31:0] hi, lo; int cyc, gr, sb; bit to;
    do_mul32(32'hDEAD_0001, 32'h0000_1003, 100, 7, hi, lo, cyc, gr, sb, to);
    total++; if (to || cyc != 33 || {hi, lo} !== 64'hDEAD_0001 * 64'h0000_1003) begin bad++;
      $display("FAIL start_in_run: got %h cycles=%0d required %h 33",
               {hi, lo}, cyc, 64'hDEAD_0001 * 64'h0000_1003); end
  endtask

  task automatic test_start_on_done();
    logic [31:0] hi, lo; int cyc, gr, sb, n; bit to;
    do_mul32(32'd11, 32'd13, 100, -1, hi, lo, cyc, gr, sb, to);
    b32.start_i  = 1'b1;
    b32.mcand_i  = 32'h0001_0001;
    b32.mplier_i = 32'h0000_0101;
    total++; if (b32.done_o !== 1'b1 || lo !== 32'd143) begin bad++;
      $display("FAIL done_with_start: done=%b lo=%0d required 1 143", b32.done_o, lo); end
    @(posedge clk); #1;
    b32.start_i = 1'b0;
    total++; if (b32.busy_o !== 1'b1 || b32.prod_hi_o !== 32'd0 || b32.prod_lo_o !== 32'h0000_0101) begin bad++;
      $display("FAIL restart_load: busy=%b hi=%h lo=%h required 1 0 00000101",
               b32.busy_o, b32.prod_hi_o, b32.prod_lo_o); end
    n = 1;
    while (!b32.done_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    total++; if (n != 33 || {b32.prod_hi_o, b32.prod_lo_o} !== 64'h0000_0000_0101_0101) begin bad++;
      $display("FAIL restart_prod: got %h cycles=%0d required 0000000001010101 33",
               {b32.prod_hi_o, b32.prod_lo_o}, n); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] hi, lo; int cyc, gr, sb; bit to;
    @(posedge clk); #1;
    b32.start_i = 1'b1; b32.mcand_i = 32'hABCD_1234; b32.mplier_i = 32'hFFFF_0F0F;
    @(posedge clk); #1;
    b32.start_i = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    total++; if (b32.busy_o !== 1'b1 || b32.alu_req_o !== 1'b1) begin bad++;
      $display("FAIL midrun_busy: busy=%b req=%b required 1 1", b32.busy_o, b32.alu_req_o); end
    rst = 1'b1;
    #1;
    total++; if (b32.busy_o !== 1'b0 || b32.alu_req_o !== 1'b0 ||
                 {b32.prod_hi_o, b32.prod_lo_o} !== 64'd0 || b32.alu_src1_o !== 32'd0) begin bad++;
      $display("FAIL async_reset: busy=%b req=%b prod=%h src1=%h required 0",
               b32.busy_o, b32.alu_req_o, {b32.prod_hi_o, b32.prod_lo_o}, b32.alu_src1_o); end
    #1;
    rst = 1'b0;
    do_mul32(32'd7, 32'd9, 100, -1, hi, lo, cyc, gr, sb, to);
    total++; if (to || hi !== 32'd0 || lo !== 32'd63) begin bad++;
      $display("FAIL after_reset_prod: got %h_%h required 0_3f", hi, lo); end
  endtask

  task automatic test_width4();
    logic [3:0] av [2];
    logic [3:0] bv [2];
    int n;
    av[0] = 4'hF; bv[0] = 4'hF;
    av[1] = 4'h0; bv[1] = 4'hA;
    for (int unsigned i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      b4.start_i = 1'b1; b4.mcand_i = av[i]; b4.mplier_i = bv[i];
      @(posedge clk); #1;
      b4.start_i = 1'b0;
      n = 1;
      while (!b4.done_o && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      total++; if (n != 5 || {b4.prod_hi_o, b4.prod_lo_o} !== 8'(av[i]) * 8'(bv[i])) begin bad++;
        $display("FAIL w4_%0d: got %h cycles=%0d required %h 5",
                 i, {b4.prod_hi_o, b4.prod_lo_o}, n, 8'(av[i]) * 8'(bv[i])); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_stall();
    test_random();
    test_start_in_run();
    test_start_on_done();
    test_reset_mid_run();
    test_width4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
